// File: rtl/rom_loader_pkg.sv
//------------------------------------------------------------------------------
// Module   : rom_loader_pkg
// Purpose  : Shared FSM encodings and frame constants for the ROM boot loader.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rom_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN0 = 3'd1,
        ST_LEN1 = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    localparam int c_LEN_BYTES      = 2;
    localparam int c_BYTES_PER_WORD = 4;

endpackage

`default_nettype wire

// File: rtl/rom_loader_packer.sv
//------------------------------------------------------------------------------
// Module   : rom_loader_packer
// Purpose  : Packs four stream bytes (LSB first) into one 32-bit word.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rom_loader_packer
    import rom_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_cnt;
    logic [23:0] r_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 2'd0;
            r_sh  <= 24'd0;
        end else if (i_clr) begin
            r_cnt <= 2'd0;
        end else if (i_valid) begin
            r_cnt <= r_cnt + 2'd1;
            r_sh  <= {i_byte, r_sh[23:8]};
        end
    end

    // The fourth byte is combined directly so the word is ready on its accept edge.
    assign o_word_valid = i_valid && (r_cnt == 2'(c_BYTES_PER_WORD - 1));
    assign o_word       = {i_byte, r_sh};

endmodule

`default_nettype wire

// File: rtl/rom_loader.sv
//------------------------------------------------------------------------------
// Module   : rom_loader
// Purpose  : Boot loader writing a length-prefixed byte stream into instruction
//            ROM; optional trailing XOR checksum when ROM_LOADER_CSUM_EN is set.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              rom_we_o,
    output logic [ADDR_W-1:0] rom_waddr_o,
    output logic [DATA_W-1:0] rom_wdata_o,
    output logic              core_rstn_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   words_o
);

    localparam logic [ADDR_W:0] c_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              r_state;
    logic [7:0]          r_len_lo;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W:0]     r_words;
    logic                r_rx_ready;
    logic                r_we;
    logic [ADDR_W-1:0]   r_waddr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_core_rstn;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
`ifdef ROM_LOADER_CSUM_EN
    logic [7:0]          r_csum;
`endif

    logic                w_accept;
    logic                w_start_ok;
    logic [15:0]         w_len;
    logic                w_too_big;
    logic                w_last_word;
    logic                w_word_valid;
    logic [31:0]         w_word;

    assign w_accept    = rx_valid_i & r_rx_ready;
    assign w_start_ok  = start_i && (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERR);
    assign w_len       = {rx_data_i, r_len_lo};
    assign w_too_big   = ({1'b0, w_len} > (17'd1 << ADDR_W));
    assign w_last_word = (r_words + c_ONE) == r_len;

    rom_loader_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_start_ok),
        .i_valid      (w_accept && (r_state == ST_DATA)),
        .i_byte       (rx_data_i),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_len_lo    <= 8'd0;
            r_len       <= '0;
            r_words     <= '0;
            r_rx_ready  <= 1'b0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_core_rstn <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef ROM_LOADER_CSUM_EN
            r_csum      <= 8'd0;
`endif
        end else begin
            r_we <= 1'b0;
            if (w_word_valid) begin
                r_we    <= 1'b1;
                r_waddr <= r_words[ADDR_W-1:0];
                r_wdata <= w_word;
                r_words <= r_words + c_ONE;
            end

            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_i) begin
                        r_state     <= ST_LEN0;
                        r_words     <= '0;
                        r_rx_ready  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                        r_core_rstn <= 1'b0;
`ifdef ROM_LOADER_CSUM_EN
                        r_csum      <= 8'd0;
`endif
                    end
                end
                ST_LEN0: begin
                    if (w_accept) begin
                        r_len_lo <= rx_data_i;
                        r_state  <= ST_LEN1;
                    end
                end
                ST_LEN1: begin
                    if (w_accept) begin
                        if (w_len == 16'd0) begin
`ifdef ROM_LOADER_CSUM_EN
                            r_state     <= ST_CSUM;
`else
                            r_state     <= ST_DONE;
                            r_rx_ready  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_core_rstn <= 1'b1;
`endif
                        end else if (w_too_big) begin
                            r_state    <= ST_ERR;
                            r_rx_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_err      <= 1'b1;
                        end else begin
                            r_len   <= w_len[ADDR_W:0];
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
`ifdef ROM_LOADER_CSUM_EN
                        r_csum <= r_csum ^ rx_data_i;
`endif
                        if (w_word_valid && w_last_word) begin
`ifdef ROM_LOADER_CSUM_EN
                            r_state     <= ST_CSUM;
`else
                            r_state     <= ST_DONE;
                            r_rx_ready  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_core_rstn <= 1'b1;
`endif
                        end
                    end
                end
`ifdef ROM_LOADER_CSUM_EN
                ST_CSUM: begin
                    if (w_accept) begin
                        r_rx_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        if (rx_data_i == r_csum) begin
                            r_state     <= ST_DONE;
                            r_done      <= 1'b1;
                            r_core_rstn <= 1'b1;
                        end else begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    r_state    <= ST_IDLE;
                    r_rx_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready_o  = r_rx_ready;
    assign rom_we_o    = r_we;
    assign rom_waddr_o = r_waddr;
    assign rom_wdata_o = r_wdata;
    assign core_rstn_o = r_core_rstn;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign words_o     = r_words;

endmodule

`default_nettype wire

// File: tb/tb_rom_loader.sv
//------------------------------------------------------------------------------
// Module   : tb_rom_loader
// Purpose  : Self-checking bench for rom_loader; honours ROM_LOADER_CSUM_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_rom_loader;

    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          start_i;
    logic [7:0]    rx_data_i;
    logic          rx_valid_i;
    logic          rx_ready_o;
    logic          rom_we_o;
    logic [AW-1:0] rom_waddr_o;
    logic [31:0]   rom_wdata_o;
    logic          core_rstn_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [AW:0]   words_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [AW+31:0] exp_q[$];
    logic [31:0]    frame_q[$];
    bit             prev_we = 1'b0;

    rom_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .rx_ready_o  (rx_ready_o),
        .rom_we_o    (rom_we_o),
        .rom_waddr_o (rom_waddr_o),
        .rom_wdata_o (rom_wdata_o),
        .core_rstn_o (core_rstn_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .words_o     (words_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: every ROM write must match the oldest expected {addr,data}.
    always @(negedge clk) begin
        logic [AW+31:0] e;
        if (!rst && rom_we_o) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rom_write unexpected: got addr=%0h data=%h, expected none", rom_waddr_o, rom_wdata_o);
            end else begin
                e = exp_q.pop_front();
                if ({rom_waddr_o, rom_wdata_o} !== e || prev_we) begin
                    n_fail++;
                    $display("FAIL rom_write: got addr=%0h data=%h prev_we=%0b, expected addr=%0h data=%h single pulse",
                             rom_waddr_o, rom_wdata_o, prev_we, e[AW+31:32], e[31:0]);
                end
            end
        end
        prev_we = rom_we_o;
    end

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int n;
        if (rnd) begin
            rx_valid_i = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        n = 0;
        while (rx_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_byte timeout: rx_ready_o=%b, expected 1", rx_ready_o);
        end
        @(negedge clk);
    endtask

    // Sends LEN and the first n words of frame_q, pushing expected writes.
    task automatic send_frame(input int len, input int n, input bit rnd, input int mid_start);
        logic [31:0] w;
        send_byte(len[7:0], rnd);
        send_byte(len[15:8], rnd);
        for (int k = 0; k < n; k++) begin
            w = frame_q[k];
            exp_q.push_back({k[AW-1:0], w});
            if (k == mid_start) begin
                rx_valid_i = 1'b0;
                start_i    = 1'b1;
                @(negedge clk);
                start_i    = 1'b0;
            end
            for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], rnd);
        end
    endtask

`ifdef ROM_LOADER_CSUM_EN
    function automatic logic [7:0] frame_csum(input int n);
        logic [7:0] c = 8'h00;
        for (int k = 0; k < n; k++) c = c ^ frame_q[k][7:0] ^ frame_q[k][15:8] ^ frame_q[k][23:16] ^ frame_q[k][31:24];
        return c;
    endfunction
`endif

    task automatic wait_end();
        int n;
        rx_valid_i = 1'b0;
        @(negedge clk);
        n = 0;
        while (!(done_o || err_o) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_end timeout: done=%b err=%b, expected one set", done_o, err_o);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_tests++;
        if ({rx_ready_o, rom_we_o, rom_waddr_o, rom_wdata_o, core_rstn_o, busy_o, done_o, err_o, words_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b we=%b a=%h d=%h rstn=%b busy=%b done=%b err=%b words=%0d, expected all 0",
                     rx_ready_o, rom_we_o, rom_waddr_o, rom_wdata_o, core_rstn_o, busy_o, done_o, err_o, words_o);
        end
    endtask

    task automatic test_basic();
        frame_q = '{32'h00100013, 32'h00200093};
        pulse_start();
        n_tests++;
        if ({busy_o, rx_ready_o, core_rstn_o, done_o, err_o} !== 5'b11000) begin
            n_fail++;
            $display("FAIL basic_loading_flags: got %b, expected 11000", {busy_o, rx_ready_o, core_rstn_o, done_o, err_o});
        end
        send_frame(2, 2, 1'b0, -1);
`ifdef ROM_LOADER_CSUM_EN
        send_byte(frame_csum(2), 1'b0);
`endif
        wait_end();
        n_tests++;
        if ({done_o, err_o, core_rstn_o, busy_o, rx_ready_o} !== 5'b10100 || words_o !== 5'd2) begin
            n_fail++;
            $display("FAIL basic_done: got flags=%b words=%0d, expected 10100 words=2",
                     {done_o, err_o, core_rstn_o, busy_o, rx_ready_o}, words_o);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_writes: got %0d outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_zero_len();
        pulse_start();
        n_tests++;
        if ({done_o, core_rstn_o, busy_o} !== 3'b001 || words_o !== 5'd0) begin
            n_fail++;
            $display("FAIL restart_clears: got done=%b rstn=%b busy=%b words=%0d, expected 0 0 1 0",
                     done_o, core_rstn_o, busy_o, words_o);
        end
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
`ifdef ROM_LOADER_CSUM_EN
        send_byte(8'h00, 1'b0);
`endif
        wait_end();
        n_tests++;
        if ({done_o, err_o, core_rstn_o} !== 3'b101 || words_o !== 5'd0) begin
            n_fail++;
            $display("FAIL zero_len: got done=%b err=%b rstn=%b words=%0d, expected 1 0 1 0",
                     done_o, err_o, core_rstn_o, words_o);
        end
    endtask

    task automatic test_len_limits();
        pulse_start();
        send_byte(8'h11, 1'b0);
        send_byte(8'h00, 1'b0);
        wait_end();
        n_tests++;
        if ({done_o, err_o, core_rstn_o, busy_o, rx_ready_o} !== 5'b01000 || words_o !== 5'd0) begin
            n_fail++;
            $display("FAIL len_too_big: got flags=%b words=%0d, expected 01000 words=0",
                     {done_o, err_o, core_rstn_o, busy_o, rx_ready_o}, words_o);
        end
        frame_q = {};
        for (int k = 0; k < 16; k++) frame_q.push_back($urandom());
        pulse_start();
        send_frame(16, 16, 1'b0, -1);
`ifdef ROM_LOADER_CSUM_EN
        send_byte(frame_csum(16), 1'b0);
`endif
        wait_end();
        n_tests++;
        if ({done_o, err_o} !== 2'b10 || words_o !== 5'd16 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL len_full_capacity: got done=%b err=%b words=%0d pending=%0d, expected 1 0 16 0",
                     done_o, err_o, words_o, exp_q.size());
        end
    endtask

`ifdef ROM_LOADER_CSUM_EN
    task automatic test_csum();
        frame_q = '{32'h00100013};
        pulse_start();
        send_frame(1, 1, 1'b0, -1);
        send_byte(8'h03, 1'b0);
        wait_end();
        n_tests++;
        if ({done_o, err_o, core_rstn_o} !== 3'b101) begin
            n_fail++;
            $display("FAIL csum_good: got done=%b err=%b rstn=%b, expected 1 0 1", done_o, err_o, core_rstn_o);
        end
        pulse_start();
        send_frame(1, 1, 1'b0, -1);
        send_byte(8'h04, 1'b0);
        wait_end();
        n_tests++;
        if ({done_o, err_o, core_rstn_o} !== 3'b010 || words_o !== 5'd1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL csum_bad: got done=%b err=%b rstn=%b words=%0d pending=%0d, expected 0 1 0 1 0",
                     done_o, err_o, core_rstn_o, words_o, exp_q.size());
        end
    endtask
`endif

    task automatic test_reset_mid();
        frame_q = '{32'h11223344, 32'h55667788};
        pulse_start();
        send_frame(2, 1, 1'b0, -1);
        send_byte(8'hAA, 1'b0);
        rx_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        test_reset();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_partial: got %0d pending, expected 0", exp_q.size());
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        frame_q = '{32'hCAFEF00D, 32'h0BADBEEF};
        pulse_start();
        send_frame(2, 2, 1'b0, -1);
`ifdef ROM_LOADER_CSUM_EN
        send_byte(frame_csum(2), 1'b0);
`endif
        wait_end();
        n_tests++;
        if ({done_o, core_rstn_o} !== 2'b11 || words_o !== 5'd2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_reload: got done=%b rstn=%b words=%0d pending=%0d, expected 1 1 2 0",
                     done_o, core_rstn_o, words_o, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        frame_q = {};
        for (int k = 0; k < 5; k++) frame_q.push_back($urandom());
        pulse_start();
        send_frame(5, 5, 1'b1, 2);
`ifdef ROM_LOADER_CSUM_EN
        send_byte(frame_csum(5), 1'b1);
`endif
        wait_end();
        n_tests++;
        if ({done_o, err_o} !== 2'b10 || words_o !== 5'd5 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_valid_mid_start: got done=%b err=%b words=%0d pending=%0d, expected 1 0 5 0",
                     done_o, err_o, words_o, exp_q.size());
        end
    endtask

    initial begin
        rst        = 1'b1;
        start_i    = 1'b0;
        rx_data_i  = 8'h00;
        rx_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_basic();
        test_zero_len();
        test_len_limits();
`ifdef ROM_LOADER_CSUM_EN
        test_csum();
`endif
        test_reset_mid();
        test_back_to_back();
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
